// File: rtl/er_fetch.sv
`default_nettype none
// ============================================================================
// Module      : er_fetch
// Description : Earthrise command fetcher. Walks the command list from a
//               start address over a two-cycle-latency read port. JUMP and
//               STOP are resolved internally. Drawing commands are handed to
//               the drawing engine through a 4-entry prefetch FIFO with a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module er_fetch #(
    parameter int WORD  = 32,
    parameter int ADDRW = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDRW-1:0] start_addr,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] addr_er,
    input  logic [WORD-1:0]  dout_er,
    output logic [WORD-1:0]  cmd,
    output logic             cmd_valid,
    input  logic             cmd_ready
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUN     = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [3:0] c_OP_STOP = 4'h0;
    localparam logic [3:0] c_OP_JUMP = 4'hF;
    localparam int         c_DEPTH   = 4;

    logic [1:0]       r_state;
    logic [ADDRW-1:0] r_pc;
    logic [1:0]       r_inflight;      // [0] issued last cycle, [1] data on dout_er now
    logic             r_done;
    logic [WORD-1:0]  r_fifo [c_DEPTH];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [2:0]       r_count;

    logic [3:0]       w_op;
    logic             w_ret;
    logic             w_ret_jump;
    logic             w_ret_stop;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [2:0]       w_credit_used;

    // Decode the returning list word and decide on issue/push/pop this cycle
    always_comb begin
        w_op          = dout_er[WORD-1 -: 4];
        w_ret         = r_inflight[1] && (r_state == c_RUN);
        w_ret_jump    = w_ret && (w_op == c_OP_JUMP);
        w_ret_stop    = w_ret && (w_op == c_OP_STOP);
        w_push        = w_ret && !w_ret_jump && !w_ret_stop;
        w_pop         = cmd_valid && cmd_ready;
        // Every outstanding read already owns a FIFO slot, so pushes never overflow
        w_credit_used = r_count + {2'b00, r_inflight[0]} + {2'b00, r_inflight[1]};
        w_issue       = (r_state == c_RUN) && (w_credit_used < 3'd4) &&
                        !w_ret_jump && !w_ret_stop && !abort;
    end

    // Control FSM, program counter and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_pc       <= '0;
            r_inflight <= 2'b00;
            r_done     <= 1'b0;
        end else if (abort) begin
            r_state    <= c_IDLE;
            r_inflight <= 2'b00;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_pc    <= start_addr;
                    end
                end
                c_RUN: begin
                    if (w_ret_stop) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (r_count == 3'd0) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
            if (w_ret_jump) begin
                r_pc <= dout_er[ADDRW-1:0];
            end else if (w_issue) begin
                r_pc <= r_pc + {{(ADDRW-1){1'b0}}, 1'b1};
            end
            // A JUMP or STOP makes every younger read stale
            if (w_ret_jump || w_ret_stop) begin
                r_inflight <= 2'b00;
            end else begin
                r_inflight <= {r_inflight[0], w_issue};
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else if (abort) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= dout_er;
        end
    end

    assign addr_er   = r_pc;
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;
    assign cmd_valid = (r_count != 3'd0);
    assign cmd       = cmd_valid ? r_fifo[r_rptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_er_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_er_fetch
// Description : Directed self-checking bench for er_fetch with a two-cycle
//               latency list memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_er_fetch;

    localparam int WORD  = 32;
    localparam int ADDRW = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [ADDRW-1:0] start_addr;
    logic             abort;
    logic             busy;
    logic             done;
    logic [ADDRW-1:0] addr_er;
    logic [WORD-1:0]  dout_er;
    logic [WORD-1:0]  cmd;
    logic             cmd_valid;
    logic             cmd_ready;

    logic [WORD-1:0]  mem [0:(1<<ADDRW)-1];
    logic [WORD-1:0]  r_rd1 = '0;
    logic [WORD-1:0]  r_rd2 = '0;

    int               checks   = 0;
    int               errors   = 0;
    int               done_cnt = 0;
    logic [WORD-1:0]  outq [$];

    always #5 clk = ~clk;

    er_fetch #(.WORD(WORD), .ADDRW(ADDRW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .addr_er    (addr_er),
        .dout_er    (dout_er),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready)
    );

    // List memory: address sampled at an edge, data visible two cycles after issue
    always @(posedge clk) begin
        r_rd1 <= mem[addr_er];
        r_rd2 <= r_rd1;
    end
    assign dout_er = r_rd2;

    // Record accepted commands and done pulses; watch for FIFO overflow
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) outq.push_back(cmd);
            if (done) done_cnt++;
            if (dut.w_push) begin
                checks++;
                assert (dut.r_count !== 3'd4) else begin
                    errors++;
                    $error("FAIL fifo_overflow: observed count %0d on push, expected below 4", dut.r_count);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem;
        for (int i = 0; i < (1 << ADDRW); i++) mem[i] = '0;
    endtask

    task automatic load_linear;
        clear_mem();
        mem[0] = 32'h1000_0001;
        mem[1] = 32'h2000_0002;
        mem[2] = 32'h3000_0003;
        mem[3] = 32'h0000_0000;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        check(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic pulse_start(input logic [ADDRW-1:0] a);
        start_addr = a;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic check_linear_out(input string tag);
        check({tag, "_count"}, outq.size(), 32'd3);
        if (outq.size() == 3) begin
            check({tag, "_c0"}, outq[0], 32'h1000_0001);
            check({tag, "_c1"}, outq[1], 32'h2000_0002);
            check({tag, "_c2"}, outq[2], 32'h3000_0003);
        end
    endtask

    initial begin
        int d0;
        logic stable;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cmd_ready  = 1'b0;
        start_addr = '0;
        clear_mem();
        step(2);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_done",      {31'b0, done},      32'd0);
        check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
        check("rst_cmd",       cmd,                32'd0);
        check("rst_addr",      {23'b0, addr_er},   32'd0);
        rst_n = 1'b1;
        step();

        // Linear list with consumer always ready
        load_linear();
        cmd_ready = 1'b1;
        outq.delete();
        d0 = done_cnt;
        pulse_start(9'd0);                                    // now cycle 1
        check("lin_busy_c1", {31'b0, busy}, 32'd1);
        check("lin_addr_c1", {23'b0, addr_er}, 32'd0);
        step(2);                                              // cycle 3
        check("lin_valid_c3", {31'b0, cmd_valid}, 32'd0);
        step();                                               // cycle 4
        check("lin_valid_c4", {31'b0, cmd_valid}, 32'd1);
        check("lin_cmd_c4", cmd, 32'h1000_0001);
        step();
        check("lin_cmd_c5", cmd, 32'h2000_0002);
        step();
        check("lin_cmd_c6", cmd, 32'h3000_0003);
        step();                                               // cycle 7
        check("lin_valid_c7", {31'b0, cmd_valid}, 32'd0);
        check("lin_done_c7", {31'b0, done}, 32'd0);
        step();                                               // cycle 8
        check("lin_done_c8", {31'b0, done}, 32'd1);
        check("lin_busy_c8", {31'b0, busy}, 32'd0);
        step();
        check("lin_busy_after", {31'b0, busy}, 32'd0);
        check("lin_done_pulses", done_cnt - d0, 32'd1);
        check_linear_out("lin");

        // Backpressure: consumer stalls for 20 cycles
        cmd_ready = 1'b0;
        outq.delete();
        pulse_start(9'd0);                                    // cycle 1
        step(5);                                              // cycle 6
        check("bp_addr_c6", {23'b0, addr_er}, 32'd4);
        stable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (cmd !== 32'h1000_0001) stable = 1'b0;
            step();
        end
        check("bp_cmd_stable", {31'b0, stable}, 32'd1);
        check("bp_cmd_hold", cmd, 32'h1000_0001);
        check("bp_addr_hold", {23'b0, addr_er}, 32'd4);
        check("bp_busy", {31'b0, busy}, 32'd1);
        cmd_ready = 1'b1;
        wait_done("bp_done");
        check_linear_out("bp");

        // JUMP skips the word after it
        clear_mem();
        mem[0]     = 32'h1000_00AA;
        mem[1]     = 32'hF000_0100;
        mem[2]     = 32'h2000_00BB;
        mem[9'h100] = 32'h3000_00CC;
        mem[9'h101] = 32'h0000_0000;
        outq.delete();
        pulse_start(9'd0);                                    // cycle 1
        step(4);                                              // cycle 5
        check("jmp_addr_c5", {23'b0, addr_er}, 32'h100);
        step(3);                                              // cycle 8
        check("jmp_cmd_c8", cmd, 32'h3000_00CC);
        wait_done("jmp_done");
        check("jmp_count", outq.size(), 32'd2);
        if (outq.size() == 2) begin
            check("jmp_c0", outq[0], 32'h1000_00AA);
            check("jmp_c1", outq[1], 32'h3000_00CC);
        end

        // Address wrap from the top of the list
        clear_mem();
        mem[9'h1FF] = 32'h4000_0001;
        outq.delete();
        pulse_start(9'h1FF);                                  // cycle 1
        check("wrap_addr_c1", {23'b0, addr_er}, 32'h1FF);
        step();
        check("wrap_addr_c2", {23'b0, addr_er}, 32'h000);
        wait_done("wrap_done");
        check("wrap_count", outq.size(), 32'd1);
        if (outq.size() == 1) check("wrap_c0", outq[0], 32'h4000_0001);

        // Abort with a full FIFO; abort also wins over a simultaneous start
        clear_mem();
        for (int i = 0; i < 8; i++) mem[9'h20 + i] = 32'h5000_0000 + i;
        cmd_ready = 1'b0;
        outq.delete();
        pulse_start(9'h20);
        step(10);
        check("abt_valid_pre", {31'b0, cmd_valid}, 32'd1);
        check("abt_cmd_pre", cmd, 32'h5000_0000);
        d0 = done_cnt;
        abort      = 1'b1;
        start      = 1'b1;
        start_addr = 9'h40;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abt_valid", {31'b0, cmd_valid}, 32'd0);
        check("abt_busy", {31'b0, busy}, 32'd0);
        check("abt_cmd", cmd, 32'd0);
        step(3);
        check("abt_busy_later", {31'b0, busy}, 32'd0);
        check("abt_no_done", done_cnt - d0, 32'd0);
        mem[9'h40] = 32'h6000_0001;
        mem[9'h41] = 32'h6000_0002;
        mem[9'h42] = 32'h0000_0000;
        cmd_ready = 1'b1;
        outq.delete();
        pulse_start(9'h40);
        wait_done("abt_restart_done");
        check("abt_restart_count", outq.size(), 32'd2);
        if (outq.size() == 2) begin
            check("abt_restart_c0", outq[0], 32'h6000_0001);
            check("abt_restart_c1", outq[1], 32'h6000_0002);
        end

        // Asynchronous reset in the middle of a run
        load_linear();
        cmd_ready = 1'b0;
        pulse_start(9'd0);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'b0, busy},      32'd0);
        check("arst_valid", {31'b0, cmd_valid}, 32'd0);
        check("arst_cmd",   cmd,                32'd0);
        check("arst_addr",  {23'b0, addr_er},   32'd0);
        check("arst_done",  {31'b0, done},      32'd0);
        step(2);
        rst_n = 1'b1;
        step();
        cmd_ready = 1'b1;
        outq.delete();
        pulse_start(9'd0);
        wait_done("arst_restart_done");
        check_linear_out("arst");

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
